// File: rtl/vr_pkg.sv
// vr_pkg: shared types for the valid_ready datapath blocks
package vr_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} vr_src_state_t;
endpackage

// File: rtl/valid_ready.sv
// valid_ready: single-channel valid/ready handshake bus
interface valid_ready #(parameter int DATA_WIDTH = 8);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    modport Master(output valid, output data, input ready);
    modport Slave(input valid, input data, output ready);
endinterface

// File: rtl/vr_down_counter.sv
// vr_down_counter: loadable down-counter that saturates at zero
module vr_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);
    assign zero = value == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) value <= '0;
        else if (load) value <= load_value;
        else if (en && !zero) value <= value - 1'b1;
endmodule

// File: rtl/vr_burst_source.sv
// vr_burst_source: valid_ready master emitting one arithmetic burst per accepted command
module vr_burst_source
    import vr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_start,
    input  logic [DATA_WIDTH-1:0] cmd_step,
    input  logic [LEN_WIDTH-1:0]  cmd_length,
    input  logic [GAP_WIDTH-1:0]  cmd_gap,
    input  logic                  abort,
    valid_ready.Master            txBus,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  beat_count
);
    vr_src_state_t         state, next;
    logic                  ready_en, abort_pend, accept, xfer, abort_now;
    logic [DATA_WIDTH-1:0] data_reg, step_reg;
    logic [GAP_WIDTH-1:0]  gap_reg, gap_val;
    logic [LEN_WIDTH-1:0]  rem_val;
    logic                  rem_zero, gap_zero;

    // ready_en keeps cmd_ready low until the first clock after reset release
    assign cmd_ready   = state == IDLE && ready_en;
    assign accept      = cmd_valid && cmd_ready;
    assign xfer        = state == SEND && txBus.ready;
    assign abort_now   = abort_pend || abort;
    assign txBus.valid = state == SEND;
    assign txBus.data  = data_reg;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign aborted     = done && abort_pend;

    vr_down_counter #(.WIDTH(LEN_WIDTH)) u_remaining (
        .clk(clk), .reset(reset), .load(accept), .en(xfer),
        .load_value(cmd_length), .value(rem_val), .zero(rem_zero)
    );

    vr_down_counter #(.WIDTH(GAP_WIDTH)) u_gap_timer (
        .clk(clk), .reset(reset), .load(xfer), .en(state == GAP),
        .load_value(gap_reg), .value(gap_val), .zero(gap_zero)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE: if (accept) next = cmd_length == '0 ? DONE : SEND;
            SEND: if (xfer) next = (rem_val == 1 || rem_zero || abort_now) ? DONE : gap_reg == '0 ? SEND : GAP;
            GAP:  next = abort_now ? DONE : (gap_val == 1 || gap_zero) ? SEND : GAP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            abort_pend <= 1'b0;
            data_reg   <= '0;
            step_reg   <= '0;
            gap_reg    <= '0;
            beat_count <= '0;
        end else begin
            state      <= next;
            ready_en   <= 1'b1;
            abort_pend <= done ? 1'b0 : abort_pend || (busy && abort);
            if (accept) begin
                data_reg   <= cmd_start;
                step_reg   <= cmd_step;
                gap_reg    <= cmd_gap;
                beat_count <= '0;
            end
            if (xfer) begin
                data_reg   <= data_reg + step_reg;
                beat_count <= beat_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vr_burst_source.sv
// tb_vr_burst_source: randomized self-checking bench with a sink-side scoreboard
module tb_vr_burst_source;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_start = '0, cmd_step = '0, cmd_length = '0;
    logic [3:0] cmd_gap = '0;
    logic       abort = 1'b0;
    logic       busy, done, aborted;
    logic [7:0] beat_count;
    int         checks = 0, failures = 0;
    logic [7:0] got[$];
    logic       hold = 1'b0;
    logic [7:0] hold_d = '0;

    valid_ready #(.DATA_WIDTH(8)) bus ();

    vr_burst_source #(.DATA_WIDTH(8), .LEN_WIDTH(8), .GAP_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_step(cmd_step), .cmd_length(cmd_length),
        .cmd_gap(cmd_gap), .abort(abort), .txBus(bus), .busy(busy), .done(done),
        .aborted(aborted), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    // sink: collect every transferred beat and remember stalled beats
    always @(posedge clk) begin
        if (reset && bus.valid && bus.ready) got.push_back(bus.data);
        hold   = reset && bus.valid && !bus.ready;
        hold_d = bus.data;
    end

    // a stalled beat must still be offered, unchanged, on the next cycle
    always @(negedge clk) begin
        if (hold && reset) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.data !== hold_d) begin
                failures++;
                $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", bus.valid, bus.data, hold_d);
            end
        end
    end

    task automatic run_burst(input string name, input logic [7:0] start, input logic [7:0] step,
                             input logic [7:0] len, input logic [3:0] gap, input int mode, input bit do_abort);
        logic [7:0] exp[$];
        int nbeats, cyc, stall;
        bit vseen;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s cmd_ready: got %b, required 1", name, cmd_ready);
            return;
        end
        got.delete();
        cmd_valid = 1'b1; cmd_start = start; cmd_step = step; cmd_length = len; cmd_gap = gap;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_start = 8'($urandom); cmd_step = 8'($urandom); cmd_length = 8'($urandom); cmd_gap = 4'($urandom);
        cyc = 0; stall = 0; vseen = 0;
        while (1) begin
            cyc++;
            vseen |= bus.valid;
            if (done || cyc > 400) break;
            if (busy !== 1'b1) begin
                checks++; failures++;
                $display("FAIL %s busy: got %b at cycle %0d, required 1", name, busy, cyc);
            end
            abort = 1'b0;
            if (do_abort && bus.valid && got.size() == 2 && stall < 2) begin
                bus.ready = 1'b0;
                abort = stall == 0;
                stall++;
            end else bus.ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom);
            @(negedge clk);
        end
        abort = 1'b0;
        nbeats = do_abort && len > 3 ? 3 : int'(len);
        for (int i = 0; i < nbeats; i++) exp.push_back(8'(start + i * step));
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout: done=%b, required 1", name, done);
            return;
        end
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s stream: got %0d beats %p, required %p", name, got.size(), got, exp);
        end
        checks++;
        if (beat_count !== 8'(nbeats) || aborted !== (do_abort && len > 3)) begin
            failures++;
            $display("FAIL %s status: beat_count=%0d aborted=%b, required %0d %b", name, beat_count, aborted, nbeats, do_abort && len > 3);
        end
        if (mode == 0 && !do_abort) begin
            checks++;
            if (cyc != (len == 0 ? 1 : int'(len) + (int'(len) - 1) * int'(gap) + 1)) begin
                failures++;
                $display("FAIL %s latency: done after %0d cycles, required %0d", name, cyc, len == 0 ? 1 : int'(len) + (int'(len) - 1) * int'(gap) + 1);
            end
        end
        if (len == 0) begin
            checks++;
            if (vseen || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s empty: valid_seen=%b cmd_ready=%b, required 0 0", name, vseen, cmd_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || beat_count !== 8'(nbeats)) begin
            failures++;
            $display("FAIL %s idle_after: done=%b cmd_ready=%b busy=%b beat_count=%0d, required 0 1 0 %0d", name, done, cmd_ready, busy, beat_count, nbeats);
        end
    endtask

    task automatic test_reset();
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0 || bus.data !== 8'h00 || cmd_ready !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || aborted !== 1'b0 || beat_count !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h cmd_ready=%b busy=%b done=%b aborted=%b beat_count=%0d, required all 0",
                     bus.valid, bus.data, cmd_ready, busy, done, aborted, beat_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, required 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_clk_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        run_burst("basic", 8'h10, 8'h01, 8'd4, 4'd0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_burst("backpressure", 8'h10, 8'h01, 8'd4, 4'd0, 1, 0);
    endtask

    task automatic test_wrap();
        run_burst("wrap_ff", 8'hFE, 8'h01, 8'd3, 4'd0, 0, 0);
        run_burst("wrap_80", 8'h00, 8'h80, 8'd3, 4'd0, 0, 0);
    endtask

    task automatic test_empty();
        run_burst("empty", 8'h55, 8'h03, 8'd0, 4'd1, 0, 0);
    endtask

    task automatic test_gap();
        run_burst("gap", 8'h20, 8'h05, 8'd5, 4'd2, 0, 0);
    endtask

    task automatic test_abort();
        run_burst("abort", 8'h40, 8'h02, 8'd10, 4'd0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_burst("random", 8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
                      4'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
    endtask

    task automatic test_reset_mid_burst();
        bus.ready = 1'b1;
        cmd_valid = 1'b1; cmd_start = 8'h01; cmd_step = 8'h01; cmd_length = 8'd10; cmd_gap = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_burst: valid=%b busy=%b, required 0 0", bus.valid, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b1;
            checks++;
            if (done !== 1'b0 || bus.valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_done: done=%b valid=%b, required 0 0", done, bus.valid);
            end
        end
        run_burst("after_reset", 8'h07, 8'h03, 8'd3, 4'd1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_empty();
        test_gap();
        test_abort();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
